// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single req/ack memory bus; data has priority, 2-cycle grant-to-rvalid latency.
// Optional fetch-starvation guard compiled in with `define MEM_ARB_FAIR_EN (bounded by STARVE_LIMIT).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    imem_req,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic                    imem_gnt,
  output logic                    imem_rvalid,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_err,

  input  logic                    dmem_req,
  input  logic                    dmem_we,
  input  logic [DATA_WIDTH/8-1:0] dmem_be,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic                    dmem_gnt,
  output logic                    dmem_rvalid,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_err,

  output logic                    bus_req,
  output logic                    bus_we,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_ack,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("mem_port_arbiter: DATA_WIDTH must be a multiple of 8");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e                state_q, state_d;

  logic                  bus_req_q,   bus_req_d;
  logic                  bus_we_q,    bus_we_d;
  logic [BE_WIDTH-1:0]   bus_be_q,    bus_be_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;

  logic                  imem_rvalid_q, imem_rvalid_d;
  logic [DATA_WIDTH-1:0] imem_rdata_q,  imem_rdata_d;
  logic                  imem_err_q,    imem_err_d;
  logic                  dmem_rvalid_q, dmem_rvalid_d;
  logic [DATA_WIDTH-1:0] dmem_rdata_q,  dmem_rdata_d;
  logic                  dmem_err_q,    dmem_err_d;

  logic                  force_i;
  logic                  bus_done;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Counts data grants that overtook a waiting fetch; reaching LIMIT hands the next idle slot to fetch.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == IDLE) begin
      if (imem_gnt || !imem_req) begin
        starve_cnt_d = '0;
      end else if (dmem_gnt) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  assign force_i = (starve_cnt_q == LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    dmem_gnt = 1'b0;
    imem_gnt = 1'b0;
    if (state_q == IDLE) begin
      dmem_gnt = dmem_req & ~force_i;
      imem_gnt = imem_req & ~dmem_gnt;
    end
  end

  assign bus_done = bus_ack | bus_err;

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_be_d      = bus_be_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    imem_rvalid_d = 1'b0;
    imem_rdata_d  = imem_rdata_q;
    imem_err_d    = imem_err_q;
    dmem_rvalid_d = 1'b0;
    dmem_rdata_d  = dmem_rdata_q;
    dmem_err_d    = dmem_err_q;

    unique case (state_q)
      IDLE: begin
        if (dmem_gnt) begin
          state_d     = BUSY_D;
          bus_req_d   = 1'b1;
          bus_we_d    = dmem_we;
          bus_be_d    = dmem_be;
          bus_addr_d  = dmem_addr;
          bus_wdata_d = dmem_wdata;
        end else if (imem_gnt) begin
          state_d     = BUSY_I;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_be_d    = '1;
          bus_addr_d  = imem_addr;
          bus_wdata_d = '0;
        end
      end

      BUSY_I: begin
        if (bus_done) begin
          state_d       = IDLE;
          bus_req_d     = 1'b0;
          imem_rvalid_d = 1'b1;
          imem_rdata_d  = bus_ack ? bus_rdata : '0;
          imem_err_d    = bus_err;
        end
      end

      BUSY_D: begin
        if (bus_done) begin
          state_d       = IDLE;
          bus_req_d     = 1'b0;
          dmem_rvalid_d = 1'b1;
          // Stores and error-only terminations carry no read data.
          dmem_rdata_d  = (bus_ack && !bus_we_q) ? bus_rdata : '0;
          dmem_err_d    = bus_err;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_be_q      <= '0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      imem_rvalid_q <= 1'b0;
      imem_rdata_q  <= '0;
      imem_err_q    <= 1'b0;
      dmem_rvalid_q <= 1'b0;
      dmem_rdata_q  <= '0;
      dmem_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_be_q      <= bus_be_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      imem_rvalid_q <= imem_rvalid_d;
      imem_rdata_q  <= imem_rdata_d;
      imem_err_q    <= imem_err_d;
      dmem_rvalid_q <= dmem_rvalid_d;
      dmem_rdata_q  <= dmem_rdata_d;
      dmem_err_q    <= dmem_err_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_be      = bus_be_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign imem_rvalid = imem_rvalid_q;
  assign imem_rdata  = imem_rdata_q;
  assign imem_err    = imem_err_q;
  assign dmem_rvalid = dmem_rvalid_q;
  assign dmem_rdata  = dmem_rdata_q;
  assign dmem_err    = dmem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level scoreboard plus directed fetch/reset sequence.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk, resetn;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt, imem_rvalid, imem_err;
  logic [DW-1:0] imem_rdata;
  logic          dmem_req, dmem_we;
  logic [BW-1:0] dmem_be;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt, dmem_rvalid, dmem_err;
  logic [DW-1:0] dmem_rdata;
  logic          bus_req, bus_we;
  logic [BW-1:0] bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack, bus_err;
  logic [DW-1:0] bus_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding bus transaction, who owns it, and the pending response.
  bit            m_busy;
  bit            m_own_d;
  int            m_wait;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  bit            e_irv, e_drv, e_ierr, e_derr;
  logic [DW-1:0] e_ird, e_drd;
  bit            drop_i, drop_d;
  int            n_igr, n_dgr, max_run, cur_run;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit allow_new);
    bit term, force_i, e_dg, e_ig, was_busy;
    int k;
    cyc();
    if (drop_i) imem_req = 1'b0;
    if (drop_d) dmem_req = 1'b0;
    drop_i = 1'b0;
    drop_d = 1'b0;

    if (!imem_req && allow_new && $urandom_range(3) != 0) begin
      imem_req  = 1'b1;
      imem_addr = $urandom;
    end else if (imem_req && $urandom_range(9) == 0) begin
      imem_addr = $urandom;
    end
    if (!dmem_req && allow_new && $urandom_range(9) != 0) begin
      dmem_req   = 1'b1;
      dmem_we    = 1'($urandom_range(1));
      dmem_be    = BW'($urandom);
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
    end else if (dmem_req && $urandom_range(9) == 0) begin
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
    end

    bus_rdata = $urandom;
    bus_ack   = 1'b0;
    bus_err   = 1'b0;
    term      = 1'b0;
    if (m_busy) begin
      if (m_wait == 0) begin
        k       = $urandom_range(9);
        bus_ack = (k < 7) || (k == 9);
        bus_err = (k >= 7);
        term    = 1'b1;
      end else begin
        m_wait--;
      end
    end else if ($urandom_range(4) == 0) begin
      bus_ack = 1'($urandom_range(1));
      bus_err = 1'($urandom_range(1));
    end
    #2;

    force_i = FAIR && (m_starve == LIMIT);
    e_dg    = !m_busy && dmem_req && !force_i;
    e_ig    = !m_busy && imem_req && !e_dg;
    chk_eq("dmem_gnt", dmem_gnt, e_dg);
    chk_eq("imem_gnt", imem_gnt, e_ig);
    chk_eq("bus_req", bus_req, m_busy);
    if (m_busy) begin
      chk_eq("bus_addr", bus_addr, m_addr);
      chk_eq("bus_we", bus_we, m_we);
      chk_eq("bus_be", bus_be, m_be);
      if (m_we) chk_eq("bus_wdata", bus_wdata, m_wdata);
    end
    chk_eq("imem_rvalid", imem_rvalid, e_irv);
    chk_eq("dmem_rvalid", dmem_rvalid, e_drv);
    if (e_irv) begin
      chk_eq("imem_rdata", imem_rdata, e_ird);
      chk_eq("imem_err", imem_err, e_ierr);
    end
    if (e_drv) begin
      chk_eq("dmem_rdata", dmem_rdata, e_drd);
      chk_eq("dmem_err", dmem_err, e_derr);
    end

    was_busy = m_busy;
    e_irv    = 1'b0;
    e_drv    = 1'b0;
    if (!was_busy) begin
      if (e_ig || !imem_req) m_starve = 0;
      else if (e_dg) m_starve++;
    end
    if (term) begin
      m_busy = 1'b0;
      if (m_own_d) begin
        e_drv  = 1'b1;
        e_drd  = (bus_ack && !m_we) ? bus_rdata : '0;
        e_derr = bus_err;
      end else begin
        e_irv  = 1'b1;
        e_ird  = bus_ack ? bus_rdata : '0;
        e_ierr = bus_err;
      end
    end else if (e_dg) begin
      m_busy  = 1'b1;
      m_own_d = 1'b1;
      m_addr  = dmem_addr;
      m_we    = dmem_we;
      m_be    = dmem_be;
      m_wdata = dmem_wdata;
      m_wait  = $urandom_range(3);
      drop_d  = 1'b1;
      n_dgr++;
      if (imem_req) cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else if (e_ig) begin
      m_busy  = 1'b1;
      m_own_d = 1'b0;
      m_addr  = imem_addr;
      m_we    = 1'b0;
      m_be    = '1;
      m_wdata = '0;
      m_wait  = $urandom_range(3);
      drop_i  = 1'b1;
      n_igr++;
      cur_run = 0;
    end
    if (!was_busy && !imem_req) cur_run = 0;
  endtask

  initial begin
    resetn     = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = '0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    bus_ack    = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = '0;
    m_busy = 0; m_starve = 0; e_irv = 0; e_drv = 0; drop_i = 0; drop_d = 0;
    n_igr = 0; n_dgr = 0; max_run = 0; cur_run = 0;

    #3;
    chk_eq("rst_bus_req", bus_req, 1'b0);
    chk_eq("rst_bus_addr", bus_addr, '0);
    chk_eq("rst_bus_be", bus_be, '0);
    chk_eq("rst_imem_rvalid", imem_rvalid, 1'b0);
    chk_eq("rst_dmem_rvalid", dmem_rvalid, 1'b0);
    chk_eq("rst_imem_rdata", imem_rdata, '0);
    chk_eq("rst_dmem_rdata", dmem_rdata, '0);
    cyc();
    cyc();
    resetn = 1'b1;

    for (int i = 0; i < 3000; i++) step(1'b1);
    for (int i = 0; i < 60 && (m_busy || imem_req || dmem_req); i++) step(1'b0);
    chk_eq("drained", {m_busy, imem_req, dmem_req}, 3'b000);
    step(1'b0);

    chk_eq("saw_imem_grants", n_igr > 0, 1'b1);
    chk_eq("saw_dmem_grants", n_dgr > 0, 1'b1);
    if (FAIR) chk_eq("starve_bounded", max_run <= LIMIT, 1'b1);

    // Directed: fetch 0x100, assert reset mid-transaction, late ack after release.
    cyc();
    imem_req = 1'b1; imem_addr = 32'h100; dmem_req = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    #2 chk_eq("dir_imem_gnt", imem_gnt, 1'b1);
    cyc();
    imem_req = 1'b0;
    #2 chk_eq("dir_bus_req", bus_req, 1'b1);
    chk_eq("dir_bus_addr", bus_addr, 32'h100);
    chk_eq("dir_bus_be", bus_be, 4'hF);
    #1 resetn = 1'b0;
    #1 chk_eq("async_bus_req_drop", bus_req, 1'b0);
    cyc();
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #2 resetn = 1'b1;
    cyc();
    #2 chk_eq("late_ack_bus_req", bus_req, 1'b0);
    chk_eq("late_ack_imem_rvalid", imem_rvalid, 1'b0);
    chk_eq("late_ack_dmem_rvalid", dmem_rvalid, 1'b0);

    // Directed fetch-only: ack in the first bus_req cycle, rvalid two cycles after grant.
    cyc();
    bus_ack = 1'b0; imem_req = 1'b1; imem_addr = 32'h100;
    #2 chk_eq("post_rst_imem_gnt", imem_gnt, 1'b1);
    cyc();
    imem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #2 chk_eq("fetch_bus_req", bus_req, 1'b1);
    cyc();
    bus_ack = 1'b0;
    #2 chk_eq("fetch_rvalid", imem_rvalid, 1'b1);
    chk_eq("fetch_rdata", imem_rdata, 32'hDEADBEEF);
    chk_eq("fetch_err", imem_err, 1'b0);
    chk_eq("fetch_bus_req_done", bus_req, 1'b0);
    cyc();
    #2 chk_eq("fetch_rvalid_pulse", imem_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
